trade_report_tx: RTL



---
 rtl/trade_report_tx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/trade_report_tx.sv
// Trade report transmitter: buffers matching-engine trade reports in a FIFO
// and serialises each one as a framed 7-byte stream on a valid/ready link.
//
// Ports:
//   CLK, RESET    clock, asynchronous active-low reset
//   trade_valid   one-cycle strobe qualifying trade_price/trade_qty/buy_id/sell_id
//   tx_data       outbound byte, qualified by tx_valid, accepted with tx_ready
//   tx_busy       frame in progress
//   fifo_full     FIFO holds FIFO_DEPTH reports
//   drop_count    saturating count of reports lost to overflow
module trade_report_tx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       trade_valid,
    input  logic [7:0] trade_price,
    input  logic [7:0] trade_qty,
    input  logic [7:0] buy_id,
    input  logic [7:0] sell_id,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic [7:0] drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t        state;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    logic [7:0] f_price;
    logic [7:0] f_qty;
    logic [7:0] f_buy;
    logic [7:0] f_sell;
    logic [7:0] f_seq;
    logic [7:0] f_cks;
    logic [7:0] seq;
    logic [2:0] byte_idx;

    logic        pop;
    logic        push;
    logic        drop;
    logic        hs;
    logic [31:0] head;
    logic [7:0]  next_byte;

    assign head = mem[rd_ptr];
    assign pop  = (state == S_IDLE) && (count != '0);
    // A full FIFO still accepts a report when the head leaves this cycle.
    assign push = trade_valid && ((count < DEPTH_C) || pop);
    assign drop = trade_valid && !push;
    assign hs   = (state == S_SEND) && tx_valid && tx_ready;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    // Byte presented after the current one is accepted.
    always_comb begin
        next_byte = SYNC_BYTE;
        unique case (byte_idx + 3'd1)
            3'd1:    next_byte = f_price;
            3'd2:    next_byte = f_qty;
            3'd3:    next_byte = f_buy;
            3'd4:    next_byte = f_sell;
            3'd5:    next_byte = f_seq;
            3'd6:    next_byte = f_cks;
            default: next_byte = SYNC_BYTE;
        endcase
    end

    // Storage array carries no reset; validity comes from the pointers.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= {trade_price, trade_qty, buy_id, sell_id};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_full  <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_nxt;
            fifo_full <= (count_nxt == DEPTH_C);
            if (drop && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            tx_busy  <= 1'b0;
            seq      <= 8'h00;
            byte_idx <= 3'd0;
            f_price  <= 8'h00;
            f_qty    <= 8'h00;
            f_buy    <= 8'h00;
            f_sell   <= 8'h00;
            f_seq    <= 8'h00;
            f_cks    <= 8'h00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        f_price  <= head[31:24];
                        f_qty    <= head[23:16];
                        f_buy    <= head[15:8];
                        f_sell   <= head[7:0];
                        f_seq    <= seq;
                        f_cks    <= head[31:24] ^ head[23:16]
                                  ^ head[15:8] ^ head[7:0] ^ seq;
                        byte_idx <= 3'd0;
                        tx_data  <= SYNC_BYTE;
                        tx_valid <= 1'b1;
                        tx_busy  <= 1'b1;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (hs) begin
                        if (byte_idx == 3'd6) begin
                            seq      <= seq + 8'd1;
                            tx_valid <= 1'b0;
                            tx_busy  <= 1'b0;
                            tx_data  <= 8'h00;
                            byte_idx <= 3'd0;
                            state    <= S_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_data  <= next_byte;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
